// File: rtl/sfx_pkg.sv
// -----------------------------------------------------------------------------
// sfx_pkg
//   Shared definitions for the sound-effect player: the midscale sample value,
//   the channel FSM state type, channel index assignments for the game's clips
//   and the default clip lengths that the top level ties onto ch_len_i.
// -----------------------------------------------------------------------------
package sfx_pkg;

    localparam int unsigned SFX_NUM_CH   = 6;
    localparam int unsigned SFX_ADDR_W   = 15;
    localparam int unsigned SFX_SAMPLE_W = 8;

    // Silence level for an unsigned 8-bit sample stream.
    localparam logic [SFX_SAMPLE_W-1:0] SFX_MIDSCALE = 8'h80;

    // Channel index of each effect.
    localparam int unsigned CH_EXIT      = 0;
    localparam int unsigned CH_HEARTBEAT = 1;
    localparam int unsigned CH_MONSTER   = 2;
    localparam int unsigned CH_SWORD     = 3;
    localparam int unsigned CH_TREASURE  = 4;
    localparam int unsigned CH_WELCOME   = 5;

    // Default clip lengths in samples (8 kHz sample rate).
    localparam logic [SFX_ADDR_W-1:0] LEN_EXIT      = 15'd12000;
    localparam logic [SFX_ADDR_W-1:0] LEN_HEARTBEAT = 15'd4000;
    localparam logic [SFX_ADDR_W-1:0] LEN_MONSTER   = 15'd16000;
    localparam logic [SFX_ADDR_W-1:0] LEN_SWORD     = 15'd3200;
    localparam logic [SFX_ADDR_W-1:0] LEN_TREASURE  = 15'd9600;
    localparam logic [SFX_ADDR_W-1:0] LEN_WELCOME   = 15'd24000;

    typedef enum logic {
        StIdle,
        StPlay
    } ch_state_e;

    // Packs the default lengths into the flat ch_len layout (ch i at [i*ADDR_W +: ADDR_W]).
    function automatic logic [SFX_NUM_CH*SFX_ADDR_W-1:0] sfx_default_lens();
        logic [SFX_NUM_CH*SFX_ADDR_W-1:0] lens;
        lens = '0;
        lens[CH_EXIT*SFX_ADDR_W      +: SFX_ADDR_W] = LEN_EXIT;
        lens[CH_HEARTBEAT*SFX_ADDR_W +: SFX_ADDR_W] = LEN_HEARTBEAT;
        lens[CH_MONSTER*SFX_ADDR_W   +: SFX_ADDR_W] = LEN_MONSTER;
        lens[CH_SWORD*SFX_ADDR_W     +: SFX_ADDR_W] = LEN_SWORD;
        lens[CH_TREASURE*SFX_ADDR_W  +: SFX_ADDR_W] = LEN_TREASURE;
        lens[CH_WELCOME*SFX_ADDR_W   +: SFX_ADDR_W] = LEN_WELCOME;
        return lens;
    endfunction

endpackage

// File: rtl/sfx_tick_gen.sv
// -----------------------------------------------------------------------------
// sfx_tick_gen
//   Sample-rate tick generator. A counter runs 0..CLK_DIV-1 and sample_tick_o
//   is high for exactly the clk in which the count equals CLK_DIV-1.
// Ports
//   clk_i          system clock
//   reset_i        asynchronous, active-high reset
//   sample_tick_o  1-clk pulse every CLK_DIV clks (registered)
// -----------------------------------------------------------------------------
module sfx_tick_gen #(
    parameter int unsigned CLK_DIV = 3125
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic sample_tick_o
);

    localparam int unsigned       CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        // Tick is registered alongside the count so it is high while cnt_q == LAST.
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign sample_tick_o = tick_q;

endmodule

// File: rtl/sfx_player.sv
// -----------------------------------------------------------------------------
// sfx_player
//   Multi-channel one-shot sound-effect sequencer. Each channel walks its own
//   external sample ROM at the sample rate once per trigger rising edge and
//   stops itself at end of clip. Active channels are priority-selected (lowest
//   index wins) into one registered output sample, or summed with saturation
//   when the SFX_MIX_EN macro is defined.
// Ports
//   clk_i          system clock
//   reset_i        asynchronous, active-high reset
//   trigger_i      per-channel start request, rising-edge sensitive
//   ch_len_i       clip length per channel, ch i at [i*ADDR_W +: ADDR_W]
//   rom_addr_o     per-channel ROM address
//   rom_data_i     per-channel ROM data, valid 1 clk after rom_addr_o changes
//   busy_o         channel currently playing
//   done_o         1-clk pulse when a channel plays its last sample
//   sample_tick_o  1-clk pulse at the sample rate
//   sample_out_o   registered output sample
// Configuration
//   SFX_MIX_EN     defined: saturating mix of all contributing channels
//                  undefined: lowest-index contributing channel is output
// -----------------------------------------------------------------------------
module sfx_player
    import sfx_pkg::*;
#(
    parameter int unsigned NUM_CH   = 6,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned CLK_DIV  = 3125
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_CH-1:0]          trigger_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_len_i,
    output logic [NUM_CH*ADDR_W-1:0]   rom_addr_o,
    input  logic [NUM_CH*SAMPLE_W-1:0] rom_data_i,
    output logic [NUM_CH-1:0]          busy_o,
    output logic [NUM_CH-1:0]          done_o,
    output logic                       sample_tick_o,
    output logic [SAMPLE_W-1:0]        sample_out_o
);

    localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic                tick;
    logic [NUM_CH-1:0]   trig_q;
    logic                armed_q;
    logic [NUM_CH-1:0]   trig_edge;
    logic [NUM_CH-1:0]   start;
    logic [NUM_CH-1:0]   contrib;
    logic [SAMPLE_W-1:0] mix_sample;
    logic [SAMPLE_W-1:0] sample_q, sample_d;

    sfx_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .sample_tick_o (tick)
    );

    assign sample_tick_o = tick;

    // armed_q masks edges in the first clk after reset so a trigger held high
    // through reset release is not mistaken for a fresh 0->1 transition.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            trig_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            trig_q  <= trigger_i;
            armed_q <= 1'b1;
        end
    end

    assign trig_edge = trigger_i & ~trig_q & {NUM_CH{armed_q}};

    // ------------------------------------------------------------------------
    // Per-channel FSMs
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e         state_q;
        logic [ADDR_W-1:0] addr_q;
        logic [ADDR_W-1:0] len;
        logic              done_q;
        logic              fresh_q;

        assign len      = ch_len_i[i*ADDR_W +: ADDR_W];
        assign start[i] = trig_edge[i] & (len != '0);
        // fresh_q blocks a tick landing 1 clk after (re)start: the ROM has not
        // yet returned the word for address 0, so that tick is skipped.
        assign contrib[i] = tick & (state_q == StPlay) & ~start[i] & ~fresh_q;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                state_q <= StIdle;
                addr_q  <= '0;
                done_q  <= 1'b0;
                fresh_q <= 1'b0;
            end else begin
                done_q  <= 1'b0;
                fresh_q <= 1'b0;
                if (start[i]) begin
                    // Start and retrigger look the same; restart beats a coinciding tick.
                    state_q <= StPlay;
                    addr_q  <= '0;
                    fresh_q <= 1'b1;
                end else if (contrib[i]) begin
                    if (addr_q == (len - ADDR_W'(1))) begin
                        state_q <= StIdle;
                        addr_q  <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
            end
        end

        assign rom_addr_o[i*ADDR_W +: ADDR_W] = addr_q;
        assign busy_o[i]                      = (state_q == StPlay);
        assign done_o[i]                      = done_q;
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
`ifdef SFX_MIX_EN
    localparam int unsigned ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam logic signed [ACC_W-1:0] MID_EXT = {{(ACC_W-SAMPLE_W){1'b0}}, MIDSCALE};
    localparam logic signed [ACC_W-1:0] MAX_EXT = {{(ACC_W-SAMPLE_W){1'b0}}, {SAMPLE_W{1'b1}}};

    logic signed [ACC_W-1:0] acc;

    always_comb begin
        acc = MID_EXT;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (contrib[i]) begin
                acc = acc + $signed({{(ACC_W-SAMPLE_W){1'b0}}, rom_data_i[i*SAMPLE_W +: SAMPLE_W]})
                    - MID_EXT;
            end
        end
        if (acc < 0) begin
            mix_sample = '0;
        end else if (acc > MAX_EXT) begin
            mix_sample = '1;
        end else begin
            mix_sample = acc[SAMPLE_W-1:0];
        end
    end
`else
    // Walk from the top down so the lowest contributing index ends up selected.
    always_comb begin
        mix_sample = MIDSCALE;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (contrib[i]) begin
                mix_sample = rom_data_i[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end
`endif

    always_comb begin
        sample_d = tick ? mix_sample : sample_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sample_q <= MIDSCALE;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample_out_o = sample_q;

endmodule

// File: tb/tb_sfx_player.sv
module tb_sfx_player;

    localparam int NUM_CH   = 6;
    localparam int ADDR_W   = 15;
    localparam int SAMPLE_W = 8;
    localparam int CLK_DIV  = 4;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic [NUM_CH-1:0]          trigger = '0;
    logic [NUM_CH*ADDR_W-1:0]   ch_len = {6{15'd3}};
    logic [NUM_CH*ADDR_W-1:0]   rom_addr;
    logic [NUM_CH*SAMPLE_W-1:0] rom_data = '0;
    logic [NUM_CH-1:0]          busy;
    logic [NUM_CH-1:0]          done;
    logic                       sample_tick;
    logic [SAMPLE_W-1:0]        sample_out;

    int checks = 0;
    int errors = 0;
    int rom_mode = 0;

    sfx_player #(
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .SAMPLE_W (SAMPLE_W),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .trigger_i     (trigger),
        .ch_len_i      (ch_len),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .busy_o        (busy),
        .done_o        (done),
        .sample_tick_o (sample_tick),
        .sample_out_o  (sample_out)
    );

    always #5 clk = ~clk;

    // ROM model: 1-clk read latency; mode 0 returns {ch, addr}.
    function automatic logic [7:0] rom_val(input int ch, input logic [14:0] a);
        logic [31:0] c;
        c = ch;
        case (rom_mode)
            0:       return {c[3:0], a[3:0]};
            1:       return 8'hFF;
            2:       return 8'h00;
            default: return 8'h90;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            rom_data[i*SAMPLE_W +: SAMPLE_W] <= rom_val(i, rom_addr[i*ADDR_W +: ADDR_W]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns at the negedge of the clk after the next sample tick.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (sample_tick) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: got no sample_tick expected one within 20 clks");
        end
        @(negedge clk);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] t);
        trigger = t;
        @(negedge clk);
        trigger = '0;
    endtask

    typedef struct {
        logic [5:0] trig;
        int         mode;
        logic [7:0] exp_sample;
        logic [5:0] exp_busy;
        logic [5:0] exp_done;
    } vec_t;

    vec_t vecs[16];

`ifdef SFX_MIX_EN
    localparam logic [7:0] TWO_CH_90 = 8'hA0;
`else
    localparam logic [7:0] TWO_CH_90 = 8'h90;
`endif

    initial begin
        int ticks;
        int first_pos;
        bit found;

        //           trig   mode sample busy   done
        vecs[0]  = '{6'h01, 0, 8'h00, 6'h01, 6'h00};
        vecs[1]  = '{6'h00, 0, 8'h01, 6'h01, 6'h00};
        vecs[2]  = '{6'h00, 0, 8'h02, 6'h00, 6'h01};
        vecs[3]  = '{6'h00, 0, 8'h80, 6'h00, 6'h00};
        vecs[4]  = '{6'h01, 0, 8'h00, 6'h01, 6'h00};
        vecs[5]  = '{6'h04, 0, 8'h01, 6'h05, 6'h00};
        vecs[6]  = '{6'h00, 0, 8'h02, 6'h04, 6'h01};
        vecs[7]  = '{6'h00, 0, 8'h22, 6'h00, 6'h04};
        vecs[8]  = '{6'h00, 0, 8'h80, 6'h00, 6'h00};
        vecs[9]  = '{6'h3F, 1, 8'hFF, 6'h3F, 6'h00};
        vecs[10] = '{6'h00, 2, 8'h00, 6'h3F, 6'h00};
        vecs[11] = '{6'h00, 2, 8'h00, 6'h00, 6'h3F};
        vecs[12] = '{6'h06, 3, TWO_CH_90, 6'h06, 6'h00};
        vecs[13] = '{6'h00, 3, TWO_CH_90, 6'h06, 6'h00};
        vecs[14] = '{6'h00, 3, TWO_CH_90, 6'h00, 6'h06};
        vecs[15] = '{6'h00, 0, 8'h80, 6'h00, 6'h00};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_tick", 32'(sample_tick), 32'h0);
        check("rst_sample", 32'(sample_out), 32'h80);
        check("rst_addr", 32'(rom_addr[31:0]), 32'h0);
        reset = 1'b0;

        // Idle output and tick spacing.
        wait_tick();
        check("idle_sample", 32'(sample_out), 32'h80);
        check("idle_busy", 32'(busy), 32'h0);
        ticks = 0;
        first_pos = -1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (sample_tick) begin
                ticks++;
                if (first_pos < 0) first_pos = n;
            end
        end
        check("tick_count", 32'(ticks), 32'd2);
        check("tick_phase", 32'(first_pos), 32'd2);

        // Table-driven single-channel, overlap, saturation and mix vectors.
        for (int v = 0; v < 16; v++) begin
            rom_mode = vecs[v].mode;
            if (vecs[v].trig != '0) pulse(vecs[v].trig);
            wait_tick();
            check($sformatf("vec%0d_sample", v), 32'(sample_out), 32'(vecs[v].exp_sample));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            check($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
        end

        // Retrigger ch1 at its last address.
        rom_mode = 0;
        pulse(6'h02);
        wait_tick();
        check("rt_s0", 32'(sample_out), 32'h10);
        wait_tick();
        check("rt_s1", 32'(sample_out), 32'h11);
        check("rt_addr2", 32'(rom_addr[ADDR_W +: ADDR_W]), 32'd2);
        pulse(6'h02);
        check("rt_addr0", 32'(rom_addr[ADDR_W +: ADDR_W]), 32'd0);
        check("rt_busy", 32'(busy[1]), 32'd1);
        wait_tick();
        check("rt_nodone", 32'(done[1]), 32'd0);
        check("rt_sample", 32'(sample_out), 32'h10);
        check("rt_addr1", 32'(rom_addr[ADDR_W +: ADDR_W]), 32'd1);

        // Edge coinciding with a tick: restart wins, channel silent that tick.
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (sample_tick) found = 1'b1;
        end
        check("et_found", 32'(found), 32'd1);
        pulse(6'h02);
        check("et_sample", 32'(sample_out), 32'h80);
        check("et_addr", 32'(rom_addr[ADDR_W +: ADDR_W]), 32'd0);
        check("et_done", 32'(done[1]), 32'd0);
        check("et_busy", 32'(busy[1]), 32'd1);
        wait_tick();
        check("et_next", 32'(sample_out), 32'h10);

        // Reset mid-clip with trigger held high.
        trigger = 6'h01;
        wait_tick();
        check("mr_play", 32'(sample_out), 32'h00);
        #2 reset = 1'b1;
        #1;
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_sample", 32'(sample_out), 32'h80);
        check("mr_addr", 32'(rom_addr[31:0]), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("mr_held", 32'(busy), 32'h0);
        check("mr_quiet", 32'(sample_out), 32'h80);
        trigger = '0;
        @(negedge clk);
        pulse(6'h01);
        check("mr_restart", 32'(busy), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
